// File: rtl/mux4_rr_sched_if.sv
// Bundle of the request/data inputs and the valid/ready output register
// signals that sit between four producers and one downstream consumer.
interface mux4_rr_sched_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       req;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [3:0]       gnt;
  logic [1:0]       s;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             y_ready;

  modport slave (
    input  req, d0, d1, d2, d3, y_ready,
    output gnt, s, y, y_valid
  );

  modport master (
    output req, d0, d1, d2, d3, y_ready,
    input  gnt, s, y, y_valid
  );
endinterface

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler for four sources feeding a single valid/ready
// output register; drives the registered mux select s.
module mux4_rr_sched #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  mux4_rr_sched_if.slave      bus,
  output logic [1:0]          o_dbg_ptr,
  output logic                o_dbg_full
);
  // Handshake: y is transferred at any rising edge where y_valid=1 and
  // y_ready=1; while y_valid=1 and y_ready=0, y, s and ptr stay frozen.
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e           r_state;
  logic [1:0]       r_ptr;
  logic [1:0]       r_s;
  logic [3:0]       r_gnt;
  logic [WIDTH-1:0] r_y;

  logic [1:0]       w_win;
  logic [1:0]       w_cand;
  logic             w_any;
  logic             w_load;
  logic [WIDTH-1:0] w_data;

  // Scan ptr+4 down to ptr+1 so the nearest requester after ptr wins last.
  always_comb begin
    w_win  = r_ptr;
    w_cand = r_ptr;
    for (int k = 4; k >= 1; k--) begin
      w_cand = r_ptr + 2'(k);
      if (bus.req[w_cand]) w_win = w_cand;
    end
  end

  always_comb begin
    w_data = bus.d0;
    case (w_win)
      2'd0:    w_data = bus.d0;
      2'd1:    w_data = bus.d1;
      2'd2:    w_data = bus.d2;
      default: w_data = bus.d3;
    endcase
  end

  assign w_any  = |bus.req;
  assign w_load = w_any && ((r_state == ST_EMPTY) || bus.y_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_ptr   <= 2'd3;
      r_s     <= 2'd0;
      r_gnt   <= 4'd0;
      r_y     <= '0;
    end else begin
      r_gnt <= 4'd0;
      if (w_load) begin
        r_y     <= w_data;
        r_s     <= w_win;
        r_ptr   <= w_win;
        r_gnt   <= 4'b0001 << w_win;
      end
      case (r_state)
        ST_EMPTY: if (w_load) r_state <= ST_FULL;
        ST_FULL:  if (!w_load && bus.y_ready) r_state <= ST_EMPTY;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

  assign bus.y       = r_y;
  assign bus.y_valid = (r_state == ST_FULL);
  assign bus.s       = r_s;
  assign bus.gnt     = r_gnt;
  assign o_dbg_ptr   = r_ptr;
  assign o_dbg_full  = (r_state == ST_FULL);
endmodule

// File: tb/tb_mux4_rr_sched.sv
// Bench for mux4_rr_sched: directed scenarios plus randomized traffic,
// all checked against a cycle-level reference model of the arbitration rules.
module tb_mux4_rr_sched;
  logic clk;
  logic reset;
  logic [1:0] dbg_ptr4, dbg_ptr8;
  logic       dbg_full4, dbg_full8;

  mux4_rr_sched_if #(.WIDTH(4)) b4 ();
  mux4_rr_sched_if #(.WIDTH(8)) b8 ();

  mux4_rr_sched #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .bus(b4.slave),
    .o_dbg_ptr(dbg_ptr4), .o_dbg_full(dbg_full4)
  );
  mux4_rr_sched #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .bus(b8.slave),
    .o_dbg_ptr(dbg_ptr8), .o_dbg_full(dbg_full8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [3:0] m_y;
  logic       m_valid;
  int         m_s;
  int         m_ptr;
  logic [3:0] m_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] req, input logic [3:0] d0, input logic [3:0] d1,
                        input logic [3:0] d2, input logic [3:0] d3, input logic rdy);
    b4.req = req; b4.d0 = d0; b4.d1 = d1; b4.d2 = d2; b4.d3 = d3; b4.y_ready = rdy;
  endtask

  // model: what the registers hold after the coming edge
  task automatic model_step();
    logic load;
    int   idx;
    bit   found;
    if (reset) begin
      m_y = 4'h0; m_valid = 1'b0; m_s = 0; m_ptr = 3; m_gnt = 4'h0;
      return;
    end
    load = (b4.req != 4'h0) && (!m_valid || b4.y_ready);
    m_gnt = 4'h0;
    if (load) begin
      idx = 0; found = 0;
      for (int k = 1; k <= 4; k++) begin
        if (!found && b4.req[(m_ptr + k) % 4]) begin
          idx = (m_ptr + k) % 4;
          found = 1;
        end
      end
      case (idx)
        0: m_y = b4.d0;
        1: m_y = b4.d1;
        2: m_y = b4.d2;
        default: m_y = b4.d3;
      endcase
      m_valid = 1'b1;
      m_s = idx;
      m_ptr = idx;
      m_gnt = 4'(1 << idx);
    end else if (m_valid && b4.y_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("y", 32'(b4.y), 32'(m_y));
    chk("y_valid", 32'(b4.y_valid), 32'(m_valid));
    chk("s", 32'(b4.s), 32'(m_s));
    chk("gnt", 32'(b4.gnt), 32'(m_gnt));
    chk("ptr", 32'(dbg_ptr4), 32'(m_ptr));
    chk("full", 32'(dbg_full4), 32'(m_valid));
  endtask

  logic [3:0] exp_y[5];
  logic [3:0] exp_g[5];
  logic [3:0] exp_y2[3];

  initial begin
    m_y = '0; m_valid = 0; m_s = 0; m_ptr = 3; m_gnt = '0;
    b8.req = 4'h0; b8.d0 = 8'h0; b8.d1 = 8'h0; b8.d2 = 8'h0; b8.d3 = 8'h0; b8.y_ready = 1'b1;
    set_in(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // reset held two cycles
    tick(); tick();
    chk("rst_y", 32'(b4.y), 32'h0);
    chk("rst_valid", 32'(b4.y_valid), 32'h0);
    chk("rst_s", 32'(b4.s), 32'h0);
    chk("rst_gnt", 32'(b4.gnt), 32'h0);
    chk("rst_ptr", 32'(dbg_ptr4), 32'h3);

    // all sources requesting: strict rotation starting at 0
    reset = 1'b0;
    set_in(4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1);
    exp_y = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rot_y", 32'(b4.y), 32'(exp_y[i]));
      chk("rot_s", 32'(b4.s), 32'(i % 4));
      chk("rot_gnt", 32'(b4.gnt), 32'(exp_g[i]));
    end
    tick(); tick(); tick();
    chk("to3_s", 32'(b4.s), 32'h3);

    // sparse requests after a grant to 3: wrap to 0, then 2, then 0
    set_in(4'b0101, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1);
    exp_y2 = '{4'hA, 4'hC, 4'hA};
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sparse_y", 32'(b4.y), 32'(exp_y2[i]));
      chk("sparse_s", 32'(b4.s), 32'((i == 1) ? 2 : 0));
    end

    // backpressure with y=5 held
    set_in(4'b0010, 4'hA, 4'h5, 4'hC, 4'hD, 1'b1);
    tick();
    chk("bp_load_y", 32'(b4.y), 32'h5);
    set_in(4'b0010, 4'hA, 4'h6, 4'hC, 4'hD, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_y", 32'(b4.y), 32'h5);
      chk("bp_valid", 32'(b4.y_valid), 32'h1);
      chk("bp_gnt", 32'(b4.gnt), 32'h0);
      chk("bp_s", 32'(b4.s), 32'h1);
    end
    b4.y_ready = 1'b1;
    tick();
    chk("bp_rel_y", 32'(b4.y), 32'h6);
    chk("bp_rel_gnt", 32'(b4.gnt), 32'b0010);

    // drain to empty
    b4.req = 4'h0;
    tick();
    chk("drain_valid", 32'(b4.y_valid), 32'h0);
    chk("drain_y", 32'(b4.y), 32'h6);
    chk("drain_s", 32'(b4.s), 32'h1);
    chk("drain_gnt", 32'(b4.gnt), 32'h0);

    // reset while full and stalled
    set_in(4'b1000, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1);
    tick();
    b4.y_ready = 1'b0;
    reset = 1'b1;
    tick();
    chk("mrst_valid", 32'(b4.y_valid), 32'h0);
    chk("mrst_y", 32'(b4.y), 32'h0);
    chk("mrst_s", 32'(b4.s), 32'h0);
    chk("mrst_ptr", 32'(dbg_ptr4), 32'h3);
    reset = 1'b0;
    set_in(4'b1001, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1);
    tick();
    chk("mrst_first_gnt", 32'(b4.gnt), 32'b0001);
    chk("mrst_first_y", 32'(b4.y), 32'hA);

    // 8-bit instance
    b8.d2 = 8'hF3; b8.req = 4'b0100; b8.y_ready = 1'b1;
    tick();
    chk("w8_y", 32'(b8.y), 32'hF3);
    chk("w8_s", 32'(b8.s), 32'h2);
    chk("w8_gnt", 32'(b8.gnt), 32'b0100);
    b8.req = 4'h0;

    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
      tick();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mux4_rr_sched.md
# mux4_rr_sched

Round-robin scheduler and output register placed directly upstream of the 4-to-1 multiplexer datapath. It watches four request lines and chooses one source per accepted transfer with rotating priority. It drives the 2-bit select that the mux4 stage consumes and captures the selected word into a valid/ready output register. This lets four producers share one downstream consumer fairly, with backpressure.

## Interface
Parameters:
- WIDTH, 4, data width of each source word and of y

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  4  per-source request; bit i means d<i> holds a word to send
- d0  input  WIDTH  source 0 data
- d1  input  WIDTH  source 1 data
- d2  input  WIDTH  source 2 data
- d3  input  WIDTH  source 3 data
- gnt  output  4  one-hot, one-cycle pulse; bit i means d<i> was captured at the preceding edge
- s  output  2  registered select; index of the most recently granted source
- y  output  WIDTH  registered output word
- y_valid  output  1  y holds an undelivered word
- y_ready  input  1  downstream accepts y this cycle

## Operation
- State: output register (y, y_valid), priority pointer ptr[1:0] (last granted index), registered s, gnt.
- Two-state FSM:
  - EMPTY: y_valid=0.
  - FULL: y_valid=1.
- Load condition at each rising edge: load = |req && (!y_valid || y_ready).
- Arbitration is combinational on the current req and ptr. Scan indices ptr+1, ptr+2, ptr+3, ptr+4 modulo 4. The first index i with req[i]=1 wins.
- On load:
  - y <= d<i>
  - y_valid <= 1
  - s <= i
  - ptr <= i
  - gnt <= one-hot(i)
- Transitions:
  - EMPTY -> FULL on load.
  - FULL -> FULL on load, including same-cycle drain and refill.
  - FULL -> EMPTY when y_ready=1 and !(|req).
  - FULL holds when y_ready=0: y, s and ptr are frozen, gnt=0.
- gnt is 0 in every cycle that does not follow a load edge.
- s holds its value between grants; it never changes without a grant.
- Wrap-around: ptr=3 gives priority order 0,1,2,3. The index arithmetic is 2-bit and wraps naturally.
- Requests that deassert before being granted are simply dropped; there is no internal queueing.
- A source is expected to hold req and data stable until it sees its gnt bit. It may then present the next word immediately.

## Timing
- Reset (synchronous, at the rising edge with reset=1):
  - y=0, y_valid=0, s=0, gnt=0, ptr=3 (so source 0 has first priority), FSM=EMPTY.
- Reset has priority over all other activity. A word in y is discarded when reset is asserted mid-transfer.
- Latency:
  - req[i] sampled at edge N with a load -> y, y_valid, s, gnt[i] visible after edge N (1 cycle).
  - From EMPTY, the first word appears one cycle after req rises.
- Throughput: one word per cycle while y_ready=1 and any req is asserted.
- Handshake: the transfer completes at an edge where y_valid=1 and y_ready=1. y must not change while y_valid=1 and y_ready=0.
- Simultaneous drain and refill in one edge: the new word replaces the old word, y_valid stays 1, and there is no bubble.
- All outputs come directly from flops; there is no combinational path from inputs to outputs.

## Test plan
- Reset / first grant:
  - Assert reset for 2 cycles, check y=0, y_valid=0, s=0, gnt=0.
  - Then apply req=4'b1111, d0=4'hA, d1=4'hB, d2=4'hC, d3=4'hD, y_ready=1.
  - Expect y=A,B,C,D,A on consecutive cycles, s=0,1,2,3,0, and gnt=0001,0010,0100,1000,0001.
- Sparse requests with wrap:
  - After a grant to source 3, apply req=4'b0101.
  - Expect a grant to 0 (s=0, y=d0), then to 2, then to 0.
- Backpressure:
  - Make y FULL with y=4'h5, then hold y_ready=0 for 3 cycles with req=4'b0010.
  - Expect y=5, y_valid=1, gnt=0 and s unchanged throughout.
  - Raise y_ready: expect y=d1 on the next cycle and gnt=0010 for exactly one cycle.
- Drain to EMPTY:
  - With FULL and y_ready=1, drop req to 0.
  - Expect y_valid=0 after one edge, with y and s holding their last values.
- Reset mid-operation:
  - Assert reset while FULL with y_ready=0 and req=4'b1000.
  - Expect y_valid=0, y=0, s=0, ptr=3. After reset releases with req=4'b1001, expect the first grant to source 0.
- WIDTH=8 instance:
  - d2=8'hF3, req=4'b0100.
  - Expect y=8'hF3 and s=2 one cycle later.
